// File: rtl/babbage_reader.sv
// Capture front end for the difference-engine core: presses start/nextn, samples each
// term into a small buffer and checks it against an internal difference model of h(n).
module babbage_reader #(
    parameter int PULSE  = 2,
    parameter int SETTLE = 4,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [4:0]  count,
    output logic        start,
    output logic        nextn,
    input  logic [9:0]  indata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  err_idx,
    output logic [4:0]  ncap,
    input  logic [3:0]  rd_addr,
    output logic [9:0]  rd_data
);

    typedef enum logic [2:0] {
        ARM, IDLE, S_LO, S_HI, SAMP, N_LO, N_HI, DONE
    } state_t;

    localparam logic [7:0] PULSE_M1  = 8'(PULSE - 1);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [7:0]  ph_q, ph_d;
    logic [4:0]  tgt_q, tgt_d;
    logic [4:0]  ncap_q, ncap_d;
    logic        err_q, err_d;
    logic [3:0]  err_idx_q, err_idx_d;
    logic [9:0]  he_q, he_d, fe_q, fe_d, ge_q, ge_d;
    logic        start_q, start_d, nextn_q, nextn_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [9:0]  rd_data_q;
    logic [9:0]  mem_q [DEPTH];
    logic [4:0]  count_clamped_s;

    assign count_clamped_s = (count == 5'd0)  ? 5'd1  :
                             (count > 5'd16)  ? 5'd16 : count;

    // Next-state, model step and registered-output values.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        tgt_d     = tgt_q;
        ncap_d    = ncap_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        he_d      = he_q;
        fe_d      = fe_q;
        ge_d      = ge_q;
        case (state_q)
            ARM: begin
                // Two idle cycles give the engine time to reach its wait state.
                if (ph_q == 8'd1) begin
                    state_d = IDLE;
                    ph_d    = 8'd0;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            IDLE: begin
                if (go) begin
                    tgt_d   = count_clamped_s;
                    state_d = S_LO;
                    ph_d    = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            S_LO, N_LO: begin
                if (ph_q == PULSE_M1) begin
                    state_d = (state_q == S_LO) ? S_HI : N_HI;
                    ph_d    = 8'd0;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            S_HI, N_HI: begin
                if (ph_q == SETTLE_M1) begin
                    state_d = SAMP;
                    ph_d    = 8'd0;
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            SAMP: begin
                he_d = he_q + fe_q;
                fe_d = fe_q + ge_q;
                ge_d = ge_q + 10'd6;
                // Only the first mismatch is recorded; the session keeps going.
                if ((indata != he_d) && !err_q) begin
                    err_d     = 1'b1;
                    err_idx_d = ncap_q[3:0];
                end else begin
                    err_d = err_q;
                end
                ncap_d = ncap_q + 5'd1;
                if (ncap_d == tgt_q) begin
                    state_d = DONE;
                end else begin
                    state_d = N_LO;
                end
            end
            DONE: state_d = DONE;
            default: begin
                state_d = ARM;
                ph_d    = 8'd0;
            end
        endcase
        start_d = (state_d != S_LO);
        nextn_d = (state_d != N_LO);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != ARM) && (state_d != IDLE) && (state_d != DONE);
    end

    // Control, model and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARM;
            ph_q      <= 8'd0;
            tgt_q     <= 5'd1;
            ncap_q    <= 5'd0;
            err_q     <= 1'b0;
            err_idx_q <= 4'd0;
            he_q      <= 10'd1;
            fe_q      <= 10'd5;
            ge_q      <= 10'd10;
            start_q   <= 1'b1;
            nextn_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 10'd0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            tgt_q     <= tgt_d;
            ncap_q    <= ncap_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            he_q      <= he_d;
            fe_q      <= fe_d;
            ge_q      <= ge_d;
            start_q   <= start_d;
            nextn_q   <= nextn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    // Term buffer; contents are left undefined by reset.
    always_ff @(posedge clk) begin
        if (state_q == SAMP) begin
            mem_q[ncap_q[3:0]] <= indata;
        end
    end

    assign start   = start_q;
    assign nextn   = nextn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;
    assign ncap    = ncap_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_babbage_reader.sv
// Bench for babbage_reader: a behavioural engine answers the press/release handshake
// with h(n); expected buffer contents go through a queue and are compared on readback.
module tb_babbage_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic [4:0]  count = 5'd0;
    logic        start, nextn, busy, done, err;
    logic [9:0]  indata;
    logic [3:0]  err_idx;
    logic [4:0]  ncap;
    logic [3:0]  rd_addr = 4'd0;
    logic [9:0]  rd_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q [$];

    babbage_reader #(.PULSE(2), .SETTLE(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .go(go), .count(count),
        .start(start), .nextn(nextn), .indata(indata),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx),
        .ncap(ncap), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] h(input int n);
        int v;
        v = n * n * n + 2 * n * n + 2 * n + 1;
        return 10'(v);
    endfunction

    // Behavioural engine: release of start loads term 1, release of nextn advances.
    int   eng_n;
    logic eng_ps, eng_pn;
    bit   fault = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_n  <= 0;
            eng_ps <= 1'b1;
            eng_pn <= 1'b1;
        end else begin
            eng_ps <= start;
            eng_pn <= nextn;
            if (!eng_ps && start) eng_n <= 1;
            else if (!eng_pn && nextn) eng_n <= eng_n + 1;
        end
    end
    assign indata = (fault && eng_n == 3) ? 10'd53 : h(eng_n);

    // Handshake monitor: press counts, low widths and release-to-sample distance.
    int   cyc = 0, s_fall = 0, n_fall = 0, s_press = 0, n_press = 0;
    int   s_low = 0, n_low = 0, last_rel = 0, samp_delta = 0, timing_bad = 0;
    logic p_start = 1'b1, p_nextn = 1'b1;
    logic [4:0] p_ncap = 5'd0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (p_start && !start) begin s_fall = cyc; s_press = s_press + 1; end
        if (!p_start && start) begin s_low = cyc - s_fall; last_rel = cyc; end
        if (p_nextn && !nextn) begin n_fall = cyc; n_press = n_press + 1; end
        if (!p_nextn && nextn) begin n_low = cyc - n_fall; last_rel = cyc; end
        if (ncap > p_ncap) begin
            samp_delta = cyc - last_rel;
            if (samp_delta != 5) timing_bad = timing_bad + 1;
        end
        p_start = start;
        p_nextn = nextn;
        p_ncap  = ncap;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600 && !done; i++) @(negedge clk);
        check("done_reached", done, 1);
    endtask

    task automatic run(input logic [4:0] cnt, input bit flt, input int e_err, input int e_idx);
        int nexp;
        logic [9:0] v;
        fault = flt;
        nexp  = (cnt == 5'd0) ? 1 : ((cnt > 5'd16) ? 16 : int'(cnt));
        for (int k = 0; k < nexp; k++) begin
            v = h(k + 1);
            if (flt && k == 2) v = 10'd53;
            exp_q.push_back(v);
        end
        count = cnt;
        go    = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("busy_after_go", busy, 1);
        wait_done();
        check("busy_in_done", busy, 0);
        check("ncap", ncap, nexp);
        check("err", err, e_err);
        check("err_idx", err_idx, e_idx);
        for (int k = 0; k < nexp; k++) begin
            rd_addr = 4'(k);
            @(negedge clk);
            v = exp_q.pop_front();
            check($sformatf("buf[%0d]", k), rd_data, v);
        end
    endtask

    initial begin
        int sp0, np0;
        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        check("rst_start", start, 1);
        check("rst_nextn", nextn, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_ncap", ncap, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic four-term session plus handshake timing.
        run(5'd4, 1'b0, 0, 0);
        check("start_low_cycles", s_low, 2);
        check("nextn_low_cycles", n_low, 2);
        check("release_to_sample", samp_delta, 5);
        check("timing_all_terms", timing_bad, 0);

        // go held high in DONE must not produce any further press.
        sp0 = s_press;
        np0 = n_press;
        go  = 1'b1;
        repeat (20) @(negedge clk);
        go = 1'b0;
        check("done_go_start_presses", s_press - sp0, 0);
        check("done_go_nextn_presses", n_press - np0, 0);
        check("done_sticky", done, 1);

        // Full buffer including the 10-bit wrap terms.
        do_reset();
        run(5'd16, 1'b0, 0, 0);

        // count=0 is one term: one start press, no nextn press.
        do_reset();
        sp0 = s_press;
        np0 = n_press;
        run(5'd0, 1'b0, 0, 0);
        check("cnt0_start_presses", s_press - sp0, 1);
        check("cnt0_nextn_presses", n_press - np0, 0);

        // count above 16 clamps to a full buffer.
        do_reset();
        run(5'd20, 1'b0, 0, 0);

        // Faulty engine: third term wrong, session still completes.
        do_reset();
        run(5'd4, 1'b1, 1, 2);
        fault = 1'b0;

        // Reset in the middle of the nextn press before term 3.
        do_reset();
        count = 5'd4;
        go    = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 300 && !(ncap == 5'd2 && !nextn); i++) @(negedge clk);
        check("midrst_reached_nlo", (ncap == 5'd2 && !nextn), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_start", start, 1);
        check("midrst_nextn", nextn, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ncap", ncap, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run(5'd2, 1'b0, 0, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/babbage_reader.md
Name: babbage_reader

Overview:
- Initiator/consumer for the difference-engine core: drives its `start` and `nextn` press/release handshake, samples its 10-bit `outdata` after each step, and stores the terms in a small buffer.
- Checks every captured term against an internal independent difference model of h(n) = n^3 + 2n^2 + 2n + 1 mod 1024.
- Sits beside the engine on the same clock and reset. Serves as a self-test and readout front end.

Parameters:
- PULSE, 2, cycles the handshake line is held low per press (≥1).
- SETTLE, 4, cycles after release before sampling `indata` (≥3 required for a same-clock engine).
- DEPTH, 16, buffer entries; fixed address width 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- go  in  1  level; starts a capture session when sampled high in IDLE.
- count  in  5  number of terms to capture; 0 treated as 1, >16 clamped to 16.
- start  out  1  to engine `start`; idle high.
- nextn  out  1  to engine `nextn`; idle high.
- indata  in  10  from engine `outdata`.
- busy  out  1  high from leaving IDLE until DONE.
- done  out  1  sticky high in DONE.
- err  out  1  sticky; set on first mismatch.
- err_idx  out  4  buffer index of the first mismatch.
- ncap  out  5  terms captured so far.
- rd_addr  in  4  buffer read address.
- rd_data  out  10  buffer[rd_addr]; registered, 1-cycle latency.

Behaviour:
- Reset (asynchronous, active-low): state=ARM, start=1, nextn=1, busy=0, done=0, err=0, err_idx=0, ncap=0, rd_data=0. The model resets to he=1, fe=5, ge=10. Buffer contents are undefined after reset.
- ARM: hold for 2 cycles after reset release, ignoring go. This guarantees the engine has reached its wait state. Then go to IDLE.
- IDLE: if go=1, latch the clamped count into tgt, set busy=1, go to S_LO.
- S_LO: start=0 for PULSE cycles, then go to S_HI.
- S_HI: start=1, count SETTLE cycles, then go to SAMP.
- SAMP (one cycle):
  - Write indata to buf[ncap].
  - Step the model: he+=fe, fe+=ge, ge+=6, all 10-bit wrap. Compare indata with the new he.
  - If they differ and err=0: set err=1 and err_idx=ncap.
  - Increment ncap. If ncap (new) == tgt go to DONE, else go to N_LO.
- N_LO: nextn=0 for PULSE cycles, then go to N_HI.
- N_HI: nextn=1, count SETTLE cycles, then go to SAMP.
- DONE: busy=0, done=1. start and nextn stay high. go is ignored until reset, because the engine cannot restart without its own reset.
- Model expected terms: 6, 21, 52, 105, ...
- A mismatch does not abort the session; capture always completes.
- Buffer reads are allowed in any state. A read of an address ≥ ncap returns stale or undefined data.
- Reset mid-session: the asynchronous return to reset values takes effect immediately. No partial pulse persists; start and nextn go high at once.
- go is level-sampled only in IDLE. Holding go high through DONE has no effect.
- The phase counter is 8-bit and saturating-safe for PULSE and SETTLE ≤255.

Test Plan:
- Reset, count=4, go pulse (connected to engine) -> buf[0..3]=6, 21, 52, 105; done=1, err=0, ncap=4.
- Reset, count=16 -> buf[8]=910, buf[9]=197 (wrap of 1221), buf[15]=545; err=0.
- count=0 -> exactly one start press, no nextn press; buf[0]=6, ncap=1, done=1.
- Engine replaced by bench model returning 6, 21, 53, 105 -> err=1, err_idx=2, ncap=4, done=1.
- Assert rst low during N_LO of term 3 -> start=1, nextn=1, busy=0, ncap=0 immediately. Reset both blocks, rerun count=2 -> buf[0..1]=6, 21.
- Check cycle timing:
  - start is low exactly PULSE cycles.
  - indata is sampled SETTLE+1 edges after the release.
  - go asserted in DONE causes no further start or nextn toggles.
